// File: rtl/stepgen_pkg.sv
// Shared types and widths for the step pulse shaper and its request buffer.
package stepgen_pkg;

    localparam int TIMER_W = 16;
    localparam int POS_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_e;

    // A phase of N cycles is timed by loading N-1 and running down to zero,
    // because the cycle that loads the counter is itself the first cycle of the phase.
    function automatic logic [TIMER_W-1:0] phaseLoad(input int unsigned cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/step_req_buffer.sv
// Edge detector on the raw step input feeding a single-entry request slot.
// A request that arrives while the slot is still occupied is lost and
// recorded in a sticky overflow flag.
module step_req_buffer
    import stepgen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic step_i,
    input  logic dir_i,
    input  logic consume_i,
    input  logic overflowClr_i,
    output logic pendValid_o,
    output logic pendValidNext_o,
    output logic pendDir_o,
    output logic overflow_o
);

    logic stepPrev_q;
    logic pendValid_q, pendValid_d;
    logic pendDir_q, pendDir_d;
    logic overflow_q, overflow_d;
    logic request;
    logic dropped;

    // A request is a low-to-high transition of step_i while enabled. The history
    // register keeps sampling even when disabled so that re-enabling while
    // step_i is already high does not fake an edge.
    assign request = enable_i & step_i & ~stepPrev_q;

    // The slot frees up in the same cycle the FSM takes it, so a request only
    // gets lost when the slot is full and nobody is taking it right now.
    assign dropped = request & pendValid_q & ~consume_i;

    // Next contents of the request slot and the overflow flag.
    always_comb begin
        pendValid_d = pendValid_q;
        pendDir_d   = pendDir_q;
        overflow_d  = overflow_q;
        if (!enable_i) begin
            pendValid_d = 1'b0;
        end else if (request && (!pendValid_q || consume_i)) begin
            pendValid_d = 1'b1;
            pendDir_d   = dir_i;
        end else if (consume_i) begin
            pendValid_d = 1'b0;
        end
        if (dropped) begin
            overflow_d = 1'b1;
        end else if (overflowClr_i) begin
            overflow_d = 1'b0;
        end
    end

    // Register the step history, the slot and the sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepPrev_q  <= 1'b0;
            pendValid_q <= 1'b0;
            pendDir_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            stepPrev_q  <= step_i;
            pendValid_q <= pendValid_d;
            pendDir_q   <= pendDir_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pendValid_o     = pendValid_q;
    assign pendValidNext_o = pendValid_d;
    assign pendDir_o       = pendDir_q;
    assign overflow_o      = overflow_q;

endmodule

// File: rtl/step_pulse_shaper.sv
// Turns raw step edges and a direction level into driver-safe STEP/DIR pins:
// fixed pulse width, minimum low time, direction setup before a rising step
// edge and direction hold after a falling one. Also keeps a signed count of
// the steps actually emitted.
module step_pulse_shaper
    import stepgen_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 50,
    parameter int unsigned SPACE_WIDTH = 50,
    parameter int unsigned DIR_SETUP   = 100,
    parameter int unsigned DIR_HOLD    = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    step_in,
    input  logic                    dir_in,
    output logic                    step_out,
    output logic                    dir_out,
    output logic signed [POS_W-1:0] position,
    output logic                    overflow,
    input  logic                    overflow_clr,
    output logic                    busy
);

    localparam logic [TIMER_W-1:0] PULSE_LOAD = phaseLoad(PULSE_WIDTH);
    localparam logic [TIMER_W-1:0] SPACE_LOAD = phaseLoad(SPACE_WIDTH);
    localparam logic [TIMER_W-1:0] SETUP_LOAD = phaseLoad(DIR_SETUP);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(DIR_HOLD);

    state_e                    state_q;
    logic [TIMER_W-1:0]        cnt_q;
    logic [TIMER_W-1:0]        hold_q;
    logic                      step_q;
    logic                      dir_q;
    logic signed [POS_W-1:0]   pos_q;
    logic                      busy_q;

    logic pendValid;
    logic pendValid_d;
    logic pendDir;
    logic overflowFlag;

    logic cntZero;
    logic holdExpired;
    logic sameDir;
    logic consume;
    logic stepRise;
    logic pulseEnd;
    logic activeNext;
    logic busy_d;

    step_req_buffer uReqBuffer (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable),
        .step_i          (step_in),
        .dir_i           (dir_in),
        .consume_i       (consume),
        .overflowClr_i   (overflow_clr),
        .pendValid_o     (pendValid),
        .pendValidNext_o (pendValid_d),
        .pendDir_o       (pendDir),
        .overflow_o      (overflowFlag)
    );

    assign cntZero     = (cnt_q == '0);
    assign holdExpired = (hold_q == '0);
    assign sameDir     = (pendDir == dir_q);

    // The FSM only takes a request from IDLE, and only when it can act on it
    // immediately: either the direction already matches, or the previous pulse's
    // hold window has fully elapsed so DIR may move. Otherwise it stays pending.
    assign consume = enable & (state_q == IDLE) & pendValid & (sameDir | holdExpired);

    // Rising step edges happen straight from IDLE on a same-direction request or
    // at the end of the setup window.
    assign stepRise = (consume & sameDir) | ((state_q == SETUP) & cntZero);

    // Falling step edge, which also opens the direction hold window.
    assign pulseEnd = (state_q == HIGH) & cntZero;

    // Whether the FSM will be outside IDLE after this edge; lets busy be a true
    // register instead of a decode of current state.
    assign activeNext = consume
                      | (state_q == SETUP)
                      | (state_q == HIGH)
                      | ((state_q == LOW) & ~cntZero);

    assign busy_d = activeNext | pendValid_d;

    // Pulse sequencing FSM: one shared down-counter times setup, high and low
    // phases; step and dir pins are driven straight from its registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (consume) begin
                        if (sameDir) begin
                            step_q  <= 1'b1;
                            cnt_q   <= PULSE_LOAD;
                            state_q <= HIGH;
                        end else begin
                            dir_q   <= pendDir;
                            cnt_q   <= SETUP_LOAD;
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cntZero) begin
                        step_q  <= 1'b1;
                        cnt_q   <= PULSE_LOAD;
                        state_q <= HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HIGH: begin
                    if (cntZero) begin
                        step_q  <= 1'b0;
                        cnt_q   <= SPACE_LOAD;
                        state_q <= LOW;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                LOW: begin
                    if (cntZero) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Direction hold timer: reloaded on every falling step edge, then runs
    // down and parks at zero. Reset parks it at zero so the very first
    // direction change needs no wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (pulseEnd) begin
            hold_q <= HOLD_LOAD;
        end else if (!holdExpired) begin
            hold_q <= hold_q - 1'b1;
        end
    end

    // Position follows the pins: counted on the rising edge in the direction
    // DIR is showing at that moment, wrapping freely at the register width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
        end else if (stepRise) begin
            if (dir_q) begin
                pos_q <= pos_q + POS_W'(1);
            end else begin
                pos_q <= pos_q - POS_W'(1);
            end
        end
    end

    // Busy covers both an active pulse sequence and a request still waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign step_out = step_q;
    assign dir_out  = dir_q;
    assign position = pos_q;
    assign overflow = overflowFlag;
    assign busy     = busy_q;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Directed bench for the step pulse shaper using small timing parameters so
// every edge position can be worked out by hand.
module tb_step_pulse_shaper;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               step_in;
    logic               dir_in;
    logic               step_out;
    logic               dir_out;
    logic signed [31:0] position;
    logic               overflow;
    logic               overflow_clr;
    logic               busy;

    int compared;
    int mismatched;

    // Edge log filled by the monitor; indices are in monitor cycle numbers.
    int cyc;
    int riseCount;
    int fallCount;
    int dirChgCount;
    int riseAt[16];
    int fallAt[16];
    int dirChgAt[16];
    logic stepPrev;
    logic dirPrev;

    step_pulse_shaper #(
        .PULSE_WIDTH (4),
        .SPACE_WIDTH (3),
        .DIR_SETUP   (5),
        .DIR_HOLD    (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .step_out     (step_out),
        .dir_out      (dir_out),
        .position     (position),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Records when step_out rises/falls and dir_out changes, sampled 1 time unit
    // after each rising clock edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (step_out && !stepPrev) begin
            if (riseCount < 16) riseAt[riseCount] = cyc;
            riseCount = riseCount + 1;
        end
        if (!step_out && stepPrev) begin
            if (fallCount < 16) fallAt[fallCount] = cyc;
            fallCount = fallCount + 1;
        end
        if (dir_out !== dirPrev) begin
            if (dirChgCount < 16) dirChgAt[dirChgCount] = cyc;
            dirChgCount = dirChgCount + 1;
        end
        stepPrev = step_out;
        dirPrev  = dir_out;
    end

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearLog();
        riseCount   = 0;
        fallCount   = 0;
        dirChgCount = 0;
    endtask

    // Pulse reset across one rising edge, leaving the bench at a falling edge.
    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearLog();
    endtask

    // One step_in edge at the current falling edge; returns the monitor cycle
    // number in effect when it was driven. Ends one falling edge later.
    task automatic applyStimulus(input logic d, output int reqCyc);
        step_in = 1'b1;
        dir_in  = d;
        reqCyc  = cyc;
        @(negedge clk);
        step_in = 1'b0;
    endtask

    // Wait until the shaper is idle with step_out low, bounded.
    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            if (!busy && !step_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if (step_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_step_out: got %b want 0", step_out); end
        compared++;
        if (dir_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dir_out: got %b want 0", dir_out); end
        compared++;
        if (position !== 32'sd0) begin mismatched++; $display("[TB] FAIL reset_position: got %0d want 0", position); end
        compared++;
        if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        clearLog();
    endtask

    task automatic test_single_step();
        int r0;
        bit ok;
        applyReset();
        applyStimulus(1'b0, r0);
        waitIdle(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL single_timeout: idle not reached, want idle within 80 cycles"); end
        compared++;
        if (riseCount !== 1) begin mismatched++; $display("[TB] FAIL single_count: got %0d pulses want 1", riseCount); end
        compared++;
        if (riseAt[0] - r0 !== 2) begin mismatched++; $display("[TB] FAIL single_latency: got %0d want 2", riseAt[0] - r0); end
        compared++;
        if (fallAt[0] - riseAt[0] !== 4) begin mismatched++; $display("[TB] FAIL single_width: got %0d want 4", fallAt[0] - riseAt[0]); end
        compared++;
        if (dir_out !== 1'b0 || dirChgCount !== 0) begin mismatched++; $display("[TB] FAIL single_dir: got %b/%0d changes want 0/0", dir_out, dirChgCount); end
        compared++;
        if (position !== -32'sd1) begin mismatched++; $display("[TB] FAIL single_position: got %0d want -1", position); end
    endtask

    task automatic test_dir_setup();
        int r0;
        bit ok;
        applyReset();
        applyStimulus(1'b1, r0);
        waitIdle(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL setup_timeout: idle not reached, want idle within 80 cycles"); end
        compared++;
        if (dirChgAt[0] - r0 !== 2) begin mismatched++; $display("[TB] FAIL setup_dir_time: got %0d want 2", dirChgAt[0] - r0); end
        compared++;
        if (riseAt[0] - dirChgAt[0] !== 5) begin mismatched++; $display("[TB] FAIL setup_rise_gap: got %0d want 5", riseAt[0] - dirChgAt[0]); end
        compared++;
        if (fallAt[0] - riseAt[0] !== 4) begin mismatched++; $display("[TB] FAIL setup_width: got %0d want 4", fallAt[0] - riseAt[0]); end
        compared++;
        if (dir_out !== 1'b1 || position !== 32'sd1) begin mismatched++; $display("[TB] FAIL setup_state: got dir %b pos %0d want dir 1 pos 1", dir_out, position); end
    endtask

    task automatic test_dir_hold();
        int r0;
        int r1;
        bit ok;
        applyReset();
        applyStimulus(1'b1, r0);
        @(negedge clk);
        applyStimulus(1'b0, r1);
        waitIdle(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL hold_timeout: idle not reached, want idle within 80 cycles"); end
        compared++;
        if (riseCount !== 2 || dirChgCount !== 2) begin mismatched++; $display("[TB] FAIL hold_counts: got %0d pulses %0d dir changes want 2/2", riseCount, dirChgCount); end
        compared++;
        if (fallAt[0] - r0 !== 11) begin mismatched++; $display("[TB] FAIL hold_first_fall: got %0d want 11", fallAt[0] - r0); end
        compared++;
        if (dirChgAt[1] - fallAt[0] !== 7) begin mismatched++; $display("[TB] FAIL hold_dir_gap: got %0d want 7", dirChgAt[1] - fallAt[0]); end
        compared++;
        if (riseAt[1] - dirChgAt[1] !== 5) begin mismatched++; $display("[TB] FAIL hold_rise_gap: got %0d want 5", riseAt[1] - dirChgAt[1]); end
        compared++;
        if (position !== 32'sd0 || dir_out !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_state: got pos %0d dir %b want pos 0 dir 0", position, dir_out); end
    endtask

    task automatic test_overflow();
        int r0;
        int r1;
        int r2;
        bit ok;
        applyReset();
        applyStimulus(1'b0, r0);
        @(negedge clk);
        applyStimulus(1'b0, r1);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_busy_pending: got %b want 1", busy); end
        @(negedge clk);
        applyStimulus(1'b0, r2);
        compared++;
        if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
        waitIdle(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL ovf_timeout: idle not reached, want idle within 80 cycles"); end
        compared++;
        if (riseCount !== 2) begin mismatched++; $display("[TB] FAIL ovf_pulses: got %0d want 2", riseCount); end
        compared++;
        if (position !== -32'sd2) begin mismatched++; $display("[TB] FAIL ovf_position: got %0d want -2", position); end
        compared++;
        if (riseAt[1] - fallAt[0] < 3) begin mismatched++; $display("[TB] FAIL ovf_low_time: got %0d want >= 3", riseAt[1] - fallAt[0]); end
        compared++;
        if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        compared++;
        if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_enable_drop();
        int r0;
        int r1;
        bit ok;
        applyReset();
        applyStimulus(1'b0, r0);
        @(negedge clk);
        applyStimulus(1'b0, r1);
        enable = 1'b0;
        waitIdle(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL en_timeout: idle not reached, want idle within 80 cycles"); end
        compared++;
        if (fallAt[0] - riseAt[0] !== 4) begin mismatched++; $display("[TB] FAIL en_width: got %0d want 4", fallAt[0] - riseAt[0]); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL en_busy: got %b want 0", busy); end
        enable = 1'b1;
        repeat (15) @(negedge clk);
        compared++;
        if (riseCount !== 1 || position !== -32'sd1) begin mismatched++; $display("[TB] FAIL en_no_more: got %0d pulses pos %0d want 1 pulse pos -1", riseCount, position); end
    endtask

    task automatic test_async_reset();
        int r0;
        bit ok;
        applyReset();
        applyStimulus(1'b0, r0);
        @(negedge clk);
        compared++;
        if (step_out !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_pre_high: got %b want 1", step_out); end
        rst = 1'b1;
        #1;
        compared++;
        if (step_out !== 1'b0 || position !== 32'sd0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL arst_immediate: got step %b pos %0d busy %b want 0/0/0", step_out, position, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        clearLog();
        applyStimulus(1'b0, r0);
        waitIdle(ok);
        compared++;
        if (!ok || riseCount !== 1 || riseAt[0] - r0 !== 2) begin
            mismatched++;
            $display("[TB] FAIL arst_after: got ok %0d pulses %0d latency %0d want 1/1/2", ok, riseCount, riseAt[0] - r0);
        end
        compared++;
        if (fallAt[0] - riseAt[0] !== 4 || position !== -32'sd1) begin
            mismatched++;
            $display("[TB] FAIL arst_after_pulse: got width %0d pos %0d want 4/-1", fallAt[0] - riseAt[0], position);
        end
    endtask

    // Runs every scenario in order and prints the single summary line.
    initial begin
        compared     = 0;
        mismatched   = 0;
        cyc          = 0;
        stepPrev     = 1'b0;
        dirPrev      = 1'b0;
        riseCount    = 0;
        fallCount    = 0;
        dirChgCount  = 0;
        for (int i = 0; i < 16; i++) begin
            riseAt[i]   = 0;
            fallAt[i]   = 0;
            dirChgAt[i] = 0;
        end
        rst          = 1'b1;
        enable       = 1'b1;
        step_in      = 1'b0;
        dir_in       = 1'b0;
        overflow_clr = 1'b0;

        test_reset();
        test_single_step();
        test_dir_setup();
        test_dir_hold();
        test_overflow();
        test_enable_drop();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/step_pulse_shaper.md
Name: step_pulse_shaper

Overview:
- Downstream of the step/dir generator.
- Turns its raw step edges and dir level into driver-safe STEP/DIR pins:
  - guaranteed pulse width
  - minimum low time
  - dir setup before a step edge
  - dir hold after a step edge
- Keeps a 1-deep request buffer and counts the steps actually emitted.
- Outputs go directly to the external stepper driver pins.

Parameters:
PULSE_WIDTH, 50, step_out high time in clk cycles (1..65535)
SPACE_WIDTH, 50, minimum step_out low time after each pulse (1..65535)
DIR_SETUP, 100, cycles dir_out must be stable before step_out rises (1..65535)
DIR_HOLD, 100, cycles after step_out falls before dir_out may change (0..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = accept step requests
step_in  in  1  raw step from upstream generator; each rising edge = one step request
dir_in  in  1  direction, sampled with the request; 1 = positive
step_out  out  1  shaped step pulse to driver
dir_out  out  1  registered direction to driver
position  out  32  signed count of emitted steps
overflow  out  1  sticky: a request was dropped
overflow_clr  in  1  clears overflow
busy  out  1  FSM not IDLE or request pending

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high (rst). All outputs registered.
- Reset values:
  - step_out=0, dir_out=0, position=0, overflow=0, busy=0
  - FSM=IDLE, pending slot empty
  - hold timer saturated, so the first dir change needs no hold wait
  - step_in history register=0
- Edge detect: request when step_in=1 and previous sample=0; dir_in is captured with it into the pending slot (valid, dir).
- Pending slot:
  - Empty, or consumed by the FSM in the same cycle: a new request is stored.
  - Full and not consumed: the new request is dropped and overflow is set.
  - Simultaneous overflow and overflow_clr: set wins.
- FSM states: IDLE, SETUP, HIGH, LOW; one 16-bit down-counter shared by all states.
- IDLE with a pending request:
  - pend_dir == dir_out: consume, step_out<=1, load PULSE_WIDTH-1, go HIGH.
  - pend_dir != dir_out and hold timer expired: consume, dir_out<=pend_dir, load DIR_SETUP-1, go SETUP.
  - Otherwise wait in IDLE; the request stays pending.
- SETUP: at count 0, step_out<=1, load PULSE_WIDTH-1, go HIGH.
- HIGH: at count 0, step_out<=0, load SPACE_WIDTH-1, restart hold timer, go LOW.
- LOW: at count 0, go IDLE. The next pulse's rising edge is no earlier than the following cycle, so low time >= SPACE_WIDTH.
- Hold timer:
  - Independent 16-bit counter, loaded with DIR_HOLD at each step_out fall.
  - Decrements to 0 and saturates; "expired" means 0.
- Position:
  - Updated in the cycle step_out rises: +1 if dir_out=1, else -1.
  - Two's-complement wrap at 32 bits, no saturation.
- Latency, idle and same direction: step_in first sampled high at edge N → step_out high after edge N+1.
- Dir change from idle with hold expired: dir_out changes after N+1; step_out rises DIR_SETUP cycles later.
- enable=0:
  - edges are ignored and the pending slot is cleared
  - a pulse in HIGH/LOW/SETUP completes normally, so there is never a runt pulse
  - in SETUP, completion means the pulse is emitted and counted
- busy = (state != IDLE) | pending_valid.
- Async rst mid-pulse: step_out drops immediately, all state returns to reset values.

Decomposition:
- Shared package stepgen_pkg:
  - state enum {IDLE, SETUP, HIGH, LOW}
  - TIMER_W = 16
  - POS_W = 32
- Sub-module step_req_buffer: edge detect, 1-deep pending slot, overflow flag.
- FSM, timers and position counter live in step_pulse_shaper.

Test Plan:
- PULSE_WIDTH=4, SPACE_WIDTH=3, DIR_SETUP=5, DIR_HOLD=6, enable=1, dir_in=0, single step_in edge → step_out high exactly 4 cycles, rises 2 cycles after the edge, dir_out stays 0, position=-1.
- Same parameters; dir_in=1 on the first request after reset → dir_out=1 one cycle after consume, step_out rises 5 cycles later, position=+1.
- Step at dir=1, then immediate request at dir=0 → dir_out changes no earlier than 6 cycles after step_out falls, step_out rises 5 cycles after the dir change, position returns to 0.
- Three step_in edges 2 cycles apart while a pulse is in HIGH → second is buffered, third is dropped, overflow=1, exactly 2 pulses emitted; overflow_clr then clears it.
- enable dropped during HIGH with a request pending → current pulse completes at full 4-cycle width, pending discarded, busy=0 after LOW, no further pulses.
- rst asserted mid-HIGH → step_out=0 and position=0 asynchronously; first post-reset same-dir step emits normally.
